// File: rtl/square_analyzer.sv
// Square-wave receive analyzer: slices samples, measures high time and period,
// and derives the duty cycle with a 7-step restoring divider.
module square_analyzer #(
    parameter int CNT_W   = 20,
    parameter int THRESH  = 2048,
    parameter int TIMEOUT = 1000000,
    parameter int TOL_PCT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      sample_in,
    input  logic             sample_valid,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic [6:0]       duty_pct,
    output logic [1:0]       duty_mode_det,
    output logic             mode_match,
    output logic             meas_valid,
    output logic             overrun,
    output logic             no_signal
);

    localparam int NW = CNT_W + 7;

    typedef enum logic [1:0] {INIT, ARM, HIGH, LOW} state_t;

    state_t           state, state_n;
    logic             prev;
    logic             primed, primed_n;
    logic [CNT_W-1:0] hcnt, hcnt_n;
    logic [CNT_W-1:0] pcnt, pcnt_n;
    logic [CNT_W-1:0] tcnt, tcnt_n;
    logic             level, rise, fall;
    logic             close, timeout;

    logic             busy;
    logic [2:0]       step;
    logic [NW-1:0]    rem, dvs;
    logic [6:0]       quo;
    logic [CNT_W-1:0] h_lat, p_lat;
    logic             finish, accept;
    logic [1:0]       mode_c;
    logic             match_c;

    assign level = (int'(sample_in) >= THRESH);
    // primed is low on the first sample after reset or timeout: no edge then
    assign rise  = primed & ~prev & level;
    assign fall  = primed & prev & ~level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= INIT;
            prev   <= 1'b0;
            primed <= 1'b0;
            hcnt   <= '0;
            pcnt   <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_n;
            primed <= primed_n;
            hcnt   <= hcnt_n;
            pcnt   <= pcnt_n;
            tcnt   <= tcnt_n;
            if (sample_valid)
                prev <= level;
        end
    end

    always_comb begin
        state_n  = state;
        primed_n = primed;
        hcnt_n   = hcnt;
        pcnt_n   = pcnt;
        tcnt_n   = tcnt;
        close    = 1'b0;
        timeout  = 1'b0;
        if (sample_valid) begin
            primed_n = 1'b1;
            unique case (state)
                INIT: state_n = ARM;
                ARM: begin
                    if (rise) begin
                        state_n = HIGH;
                        hcnt_n  = CNT_W'(1);
                        pcnt_n  = CNT_W'(1);
                    end
                end
                HIGH: begin
                    pcnt_n = pcnt + CNT_W'(1);
                    if (fall)
                        state_n = LOW;
                    else
                        hcnt_n = hcnt + CNT_W'(1);
                end
                LOW: begin
                    if (rise) begin
                        close   = 1'b1;
                        state_n = HIGH;
                        hcnt_n  = CNT_W'(1);
                        pcnt_n  = CNT_W'(1);
                    end else begin
                        pcnt_n = pcnt + CNT_W'(1);
                    end
                end
                default: state_n = INIT;
            endcase
            if (state == INIT || rise || fall) begin
                tcnt_n = '0;
            end else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
                timeout  = 1'b1;
                state_n  = ARM;
                primed_n = 1'b0;
                tcnt_n   = '0;
            end else begin
                tcnt_n = tcnt + CNT_W'(1);
            end
        end
    end

    function automatic logic near(input logic [6:0] q, input int t);
        return (int'(q) >= t - TOL_PCT) && (int'(q) <= t + TOL_PCT);
    endfunction

    always_comb begin
        mode_c  = 2'b00;
        match_c = 1'b0;
        if (near(quo, 50)) begin
            mode_c  = 2'b00;
            match_c = 1'b1;
        end else if (near(quo, 33)) begin
            mode_c  = 2'b01;
            match_c = 1'b1;
        end else if (near(quo, 25)) begin
            mode_c  = 2'b10;
            match_c = 1'b1;
        end else if (near(quo, 14)) begin
            mode_c  = 2'b11;
            match_c = 1'b1;
        end
    end

    // The finishing clk frees the divider, so a cycle closing then is taken
    assign finish = busy && (step == 3'd7);
    assign accept = close && (!busy || finish);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy          <= 1'b0;
            step          <= '0;
            rem           <= '0;
            dvs           <= '0;
            quo           <= '0;
            h_lat         <= '0;
            p_lat         <= '0;
            period_out    <= '0;
            high_out      <= '0;
            duty_pct      <= '0;
            duty_mode_det <= '0;
            mode_match    <= 1'b0;
            meas_valid    <= 1'b0;
            overrun       <= 1'b0;
            no_signal     <= 1'b1;
        end else begin
            meas_valid <= 1'b0;
            overrun    <= close && !accept;
            if (busy && !finish) begin
                if (rem >= dvs) begin
                    rem <= rem - dvs;
                    quo <= {quo[5:0], 1'b1};
                end else begin
                    quo <= {quo[5:0], 1'b0};
                end
                dvs  <= dvs >> 1;
                step <= step + 3'd1;
            end
            if (finish) begin
                busy          <= 1'b0;
                period_out    <= p_lat;
                high_out      <= h_lat;
                duty_pct      <= quo;
                duty_mode_det <= mode_c;
                mode_match    <= match_c;
                meas_valid    <= 1'b1;
                no_signal     <= 1'b0;
            end
            if (timeout)
                no_signal <= 1'b1;
            if (accept) begin
                busy  <= 1'b1;
                step  <= '0;
                quo   <= '0;
                rem   <= NW'(hcnt) * NW'(100);
                dvs   <= NW'(pcnt) << 6;
                h_lat <= hcnt;
                p_lat <= pcnt;
            end
        end
    end

endmodule

// File: tb/tb_square_analyzer.sv
// Scoreboard bench for square_analyzer: drives sliced pulse streams and
// compares every meas_valid result, its latency and the overrun count.
module tb_square_analyzer;

    localparam int CNT_W = 20;
    localparam int TMO   = 5000;

    logic             clk = 1'b0;
    logic             rst;
    logic [11:0]      sample_in;
    logic             sample_valid;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic [6:0]       duty_pct;
    logic [1:0]       duty_mode_det;
    logic             mode_match;
    logic             meas_valid;
    logic             overrun;
    logic             no_signal;

    square_analyzer #(
        .CNT_W(CNT_W),
        .THRESH(2048),
        .TIMEOUT(TMO),
        .TOL_PCT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .period_out(period_out),
        .high_out(high_out),
        .duty_pct(duty_pct),
        .duty_mode_det(duty_mode_det),
        .mode_match(mode_match),
        .meas_valid(meas_valid),
        .overrun(overrun),
        .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int p;
        int duty;
        int mode;
        int mt;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ovr_seen = 0;
    int   exp_ovr = 0;
    int   meas_seen = 0;
    int   exp_meas = 0;
    int   busy_until = 0;
    bit   pend = 0;
    int   ph = 0;
    int   pp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int h, input int p, input int due);
        exp_t e;
        int   d;
        d = (h * 100) / p;
        e.h = h;
        e.p = p;
        e.duty = d;
        e.due = due;
        e.mode = 0;
        e.mt = 1;
        if (d >= 48 && d <= 52)      e.mode = 0;
        else if (d >= 31 && d <= 35) e.mode = 1;
        else if (d >= 23 && d <= 27) e.mode = 2;
        else if (d >= 12 && d <= 16) e.mode = 3;
        else                         e.mt = 0;
        return e;
    endfunction

    // Called right after the closing sample is driven (sampled at cyc+1)
    task automatic close_cycle();
        if (pend) begin
            if (cyc + 1 >= busy_until) begin
                sb.push_back(model(ph, pp, cyc + 9));
                busy_until = cyc + 9;
                exp_meas++;
            end else begin
                exp_ovr++;
            end
        end
        pend = 0;
    endtask

    task automatic emit(input bit lvl, input int stride);
        for (int i = 0; i < stride - 1; i++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            sample_in = 12'($urandom_range(0, 4095));
        end
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in = lvl ? 12'($urandom_range(2048, 4095))
                        : 12'($urandom_range(0, 2047));
    endtask

    task automatic send_cycle(input int h, input int p, input int stride);
        for (int j = 0; j < p; j++) begin
            emit(j < h, stride);
            if (j == 0) begin
                close_cycle();
                pend = 1;
                ph = h;
                pp = p;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (overrun)
            ovr_seen++;
        if (meas_valid) begin
            meas_seen++;
            check("meas_expected", longint'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("latency", cyc, e.due);
                check("period_out", period_out, e.p);
                check("high_out", high_out, e.h);
                check("duty_pct", duty_pct, e.duty);
                check("duty_mode_det", duty_mode_det, e.mode);
                check("mode_match", mode_match, e.mt);
                check("no_signal_clr", no_signal, 0);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_period"}, period_out, 0);
        check({tag, "_high"}, high_out, 0);
        check({tag, "_duty"}, duty_pct, 0);
        check({tag, "_mode"}, duty_mode_det, 0);
        check({tag, "_match"}, mode_match, 0);
        check({tag, "_meas"}, meas_valid, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_nosig"}, no_signal, 1);
    endtask

    int hs[5] = '{2048, 585, 1365, 1024, 1517};

    initial begin
        rst = 1'b1;
        sample_in = '0;
        sample_valid = 1'b0;
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;

        repeat (5) emit(0, 1);
        foreach (hs[i]) send_cycle(hs[i], 4096, 1);
        send_cycle(2048, 4096, 3);

        emit(1, 1);
        close_cycle();
        repeat (TMO - 20) emit(1, 1);
        @(negedge clk);
        check("nosig_before_tmo", no_signal, 0);
        repeat (40) emit(1, 1);
        @(negedge clk);
        check("nosig_after_tmo", no_signal, 1);

        repeat (10) emit(0, 1);
        send_cycle(2048, 4096, 1);
        check("nosig_hold", no_signal, 1);
        for (int i = 0; i < 12; i++) send_cycle(2, 4, 1);
        emit(1, 1);
        close_cycle();
        emit(1, 1);
        emit(1, 1);
        idle(20);
        check("overrun_cnt", ovr_seen, exp_ovr);
        check("sb_drained", sb.size(), 0);
        check("period_before_rst", period_out, 4);

        #3;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        pend = 0;
        busy_until = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) emit(0, 1);
        send_cycle(1000, 3000, 1);
        check("meas_before_close", meas_seen, exp_meas);
        send_cycle(3, 10, 1);
        idle(20);

        check("sb_final", sb.size(), 0);
        check("meas_cnt", meas_seen, exp_meas);
        check("overrun_final", ovr_seen, exp_ovr);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
